// File: rtl/hcu_pkg.sv
// Shared types and constants for the hazard control unit.
package hcu_pkg;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } hcu_state_e;

  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

endpackage

// File: rtl/forwarding_unit.sv
// Operand bypass selection for one EX source operand.
// MEM has priority over WB, and register x0 is never forwarded.
module forwarding_unit
  import hcu_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] ex_rs_i,
  input  logic [REG_ADDR_W-1:0] mem_rd_i,
  input  logic                  mem_reg_write_i,
  input  logic [REG_ADDR_W-1:0] wb_rd_i,
  input  logic                  wb_reg_write_i,
  output logic [1:0]            fwd_sel_o
);

  // Pick the youngest in-flight producer of ex_rs_i.
  always_comb begin
    fwd_sel_o = FWD_REG;
    if (mem_reg_write_i && (mem_rd_i != '0) && (mem_rd_i == ex_rs_i)) begin
      fwd_sel_o = FWD_MEM;
    end else if (wb_reg_write_i && (wb_rd_i != '0) && (wb_rd_i == ex_rs_i)) begin
      fwd_sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Central sequencer for the 5-stage pipeline: bank enables/flushes, PC
// enable, EX forwarding selects, multi-cycle unit handshake with watchdog,
// and a saturating stall-cycle counter.
module hazard_control_unit
  import hcu_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned MC_TIMEOUT = 64,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rs1,
  input  logic [REG_ADDR_W-1:0] ex_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_mc_op,
  input  logic                  ex_branch_taken,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  mem_reg_write,
  input  logic                  wb_reg_write,
  input  logic                  imem_ready,
  input  logic                  dmem_ready,
  input  logic                  mc_done,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  id_ex_en,
  output logic                  ex_mem_en,
  output logic                  mem_wb_en,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  ex_mem_flush,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  mc_start,
  output logic                  mc_error,
  output logic [CNT_W-1:0]      stall_cycles
);

  localparam int unsigned    WD_W    = (MC_TIMEOUT > 1) ? $clog2(MC_TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MC_TIMEOUT - 1);

  hcu_state_e       state_q, state_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             mc_error_q, mc_error_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic [1:0] fwd_a_raw, fwd_b_raw;
  logic       lu;
  logic       mc_timeout;

  forwarding_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .ex_rs_i         (ex_rs1),
    .mem_rd_i        (mem_rd),
    .mem_reg_write_i (mem_reg_write),
    .wb_rd_i         (wb_rd),
    .wb_reg_write_i  (wb_reg_write),
    .fwd_sel_o       (fwd_a_raw)
  );

  forwarding_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .ex_rs_i         (ex_rs2),
    .mem_rd_i        (mem_rd),
    .mem_reg_write_i (mem_reg_write),
    .wb_rd_i         (wb_rd),
    .wb_reg_write_i  (wb_reg_write),
    .fwd_sel_o       (fwd_b_raw)
  );

  assign fwd_a_sel = reset ? FWD_REG : fwd_a_raw;
  assign fwd_b_sel = reset ? FWD_REG : fwd_b_raw;

  assign lu = ex_mem_read && (ex_rd != '0) &&
              ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

  // Watchdog expiry only counts on a cycle that is not frozen and has no result.
  assign mc_timeout = (state_q == MC_WAIT) && dmem_ready && !mc_done && (wd_q == WD_LAST);

  assign mc_error     = mc_error_q;
  assign stall_cycles = stall_q;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, watchdog and sticky error flag.
  // The watchdog keeps counting through a dmem freeze but stops at its last
  // value, so an expiry during a freeze is acted on at the first unfrozen cycle.
  always_comb begin
    state_d    = state_q;
    wd_d       = wd_q;
    mc_error_d = mc_error_q;
    case (state_q)
      RUN: begin
        if (dmem_ready && ex_mc_op) begin
          state_d = MC_WAIT;
          wd_d    = '0;
        end
      end
      MC_WAIT: begin
        if (dmem_ready && mc_done) begin
          state_d = RUN;
          wd_d    = '0;
        end else if (mc_timeout) begin
          state_d    = RUN;
          wd_d       = '0;
          mc_error_d = 1'b1;
        end else if (wd_q != WD_LAST) begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Pipeline bank controls, decoded in priority order.
  always_comb begin
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    id_ex_en     = 1'b0;
    ex_mem_en    = 1'b0;
    mem_wb_en    = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mc_start     = 1'b0;
    if (reset) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (!dmem_ready) begin
      // full freeze, nothing moves
    end else if (state_q == RUN) begin
      if (ex_mc_op) begin
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        ex_mem_flush = 1'b1;
        mc_start     = 1'b1;
      end else if (ex_branch_taken) begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (lu) begin
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        id_ex_flush = 1'b1;
      end else if (!imem_ready) begin
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        if_id_flush = 1'b1;
      end else begin
        pc_en     = 1'b1;
        if_id_en  = 1'b1;
        id_ex_en  = 1'b1;
        ex_mem_en = 1'b1;
        mem_wb_en = 1'b1;
      end
    end else begin
      if (mc_done) begin
        pc_en     = 1'b1;
        if_id_en  = 1'b1;
        id_ex_en  = 1'b1;
        ex_mem_en = 1'b1;
        mem_wb_en = 1'b1;
      end else if (mc_timeout) begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        ex_mem_flush = 1'b1;
      end else begin
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        ex_mem_flush = 1'b1;
      end
    end
  end

  // Saturating count of cycles where the PC is held.
  always_comb begin
    stall_d = stall_q;
    if (!pc_en && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  // Watchdog, error flag and stall counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_q       <= '0;
      mc_error_q <= 1'b0;
      stall_q    <= '0;
    end else begin
      wd_q       <= wd_d;
      mc_error_q <= mc_error_d;
      stall_q    <= stall_d;
    end
  end

endmodule
